// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch through write-back,
// drives all mux selects and enables, and halts the core when a memory access hangs.
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExecR   = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StAddiEx  = 4'd11,
        StAddiWb  = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam bit         TimeoutEn = (WAIT_LIMIT != 0);
    localparam logic [7:0] WaitLast  = 8'(WAIT_LIMIT - 1);

    state_e     state_q, state_d;
    logic       halted_q, halted_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            halted_q <= 1'b0;
            wait_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        wait_d     = wait_q;
        mem_state  = 1'b0;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!halted_q) state_d = StFetch;
            end
            StFetch: begin
                mem_state = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = 2'd3;
                case (opcode)
                    OpLw, OpSw: state_d = StMemAddr;
                    OpRtype:    state_d = StExecR;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_state = 1'b1;
                mem_read  = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_state = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'd1;
                pc_en      = zero;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_src     = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StIdle;
        endcase

        // A ready on the last allowed cycle still completes normally.
        if (mem_state && !mem_ready && TimeoutEn && (wait_q == WaitLast)) begin
            state_d  = StIdle;
            halted_d = 1'b1;
        end

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (mem_state && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    assign halted = halted_q;
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and control vectors for each instruction
// class, memory wait handshakes, timeout halt and asynchronous reset.
module tb_multicycle_ctrl;

    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, instr_done, illegal_op, halted;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic [16:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done),
        .illegal_op(illegal_op), .halted(halted), .state(state)
    );

    assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MADDR = 4'd3;
    localparam logic [3:0] S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_EXR = 4'd7;
    localparam logic [3:0] S_RWB = 4'd8, S_BR = 4'd9, S_JMP = 4'd10, S_AEX = 4'd11;
    localparam logic [3:0] S_AWB = 4'd12;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ILL = 6'b111111;

    // Field order: pc_en iord mrd mwr irw rdst m2r rw asa asb aop psrc done ill
    localparam logic [16:0] E_IDLE      = 17'd0;
    localparam logic [16:0] E_FETCH_RDY = {8'b1010_1000, 1'b0, 2'd1, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_FETCH_W   = {8'b0010_0000, 1'b0, 2'd1, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_DEC       = {8'b0000_0000, 1'b0, 2'd3, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_DEC_ILL   = {8'b0000_0000, 1'b0, 2'd3, 2'd0, 2'd0, 2'b01};
    localparam logic [16:0] E_MADDR     = {8'b0000_0000, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_MRD       = {8'b0110_0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_MWB       = {8'b0000_0011, 1'b0, 2'd0, 2'd0, 2'd0, 2'b10};
    localparam logic [16:0] E_MWR_W     = {8'b0101_0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_MWR_RDY   = {8'b0101_0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'b10};
    localparam logic [16:0] E_EXR       = {8'b0000_0000, 1'b1, 2'd0, 2'd2, 2'd0, 2'b00};
    localparam logic [16:0] E_RWB       = {8'b0000_0101, 1'b0, 2'd0, 2'd0, 2'd0, 2'b10};
    localparam logic [16:0] E_BR_Z      = {8'b1000_0000, 1'b1, 2'd0, 2'd1, 2'd1, 2'b10};
    localparam logic [16:0] E_BR_NZ     = {8'b0000_0000, 1'b1, 2'd0, 2'd1, 2'd1, 2'b10};
    localparam logic [16:0] E_JMP       = {8'b1000_0000, 1'b0, 2'd0, 2'd0, 2'd2, 2'b10};
    localparam logic [16:0] E_AEX       = {8'b0000_0000, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00};
    localparam logic [16:0] E_AWB       = {8'b0000_0001, 1'b0, 2'd0, 2'd0, 2'd0, 2'b10};

    task automatic test_reset();
        rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
        #2;
        n_tests++;
        if ({state, ctl, halted} !== {S_IDLE, E_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: state=%0d ctl=%h halted=%b, required 0/0/0", state, ctl, halted);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_tests++;
        if (state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d, required %0d", state, S_IDLE);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({state, halted} !== {S_FETCH, 1'b0}) begin
            n_fail++;
            $display("FAIL first_fetch: state=%0d halted=%b, required %0d/0", state, halted, S_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  st [6] = '{S_FETCH, S_DEC, S_MADDR, S_MRD, S_MWB, S_FETCH};
        logic [16:0] ex [6] = '{E_FETCH_RDY, E_DEC, E_MADDR, E_MRD, E_MWB, E_FETCH_RDY};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL lw[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 5) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st [8] = '{S_FETCH, S_DEC, S_MADDR, S_MWR, S_MWR, S_MWR, S_MWR, S_FETCH};
        logic [16:0] ex [8] = '{E_FETCH_RDY, E_DEC, E_MADDR, E_MWR_W, E_MWR_W, E_MWR_W,
                                E_MWR_RDY, E_FETCH_RDY};
        logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL sw[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 7) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st [13] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DEC, S_MADDR,
                                 S_MRD, S_MRD, S_MRD, S_MRD, S_MWB, S_FETCH, S_FETCH};
        logic [16:0] ex [13] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_RDY, E_DEC, E_MADDR,
                                 E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_FETCH_RDY, E_FETCH_RDY};
        logic        mr [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        opcode = OP_LW;
        for (int i = 0; i < 12; i++) begin
            mem_ready = mr[i];
            #1;
            n_tests++;
            if ({state, ctl, halted} !== {st[i], ex[i], 1'b0}) begin
                n_fail++;
                $display("FAIL lw_wait[%0d]: state=%0d ctl=%h halted=%b, required %0d/%h/0",
                         i, state, ctl, halted, st[i], ex[i]);
            end
            if (i < 11) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0]  st [4] = '{S_FETCH, S_DEC, S_BR, S_FETCH};
        logic [16:0] ex [4];
        ex = '{E_FETCH_RDY, E_DEC, (z ? E_BR_Z : E_BR_NZ), E_FETCH_RDY};
        opcode = OP_BEQ; mem_ready = 1'b1; zero = z;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL beq_z%0b[%0d]: state=%0d ctl=%h, required %0d/%h",
                         z, i, state, ctl, st[i], ex[i]);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [3:0]  st [4] = '{S_FETCH, S_DEC, S_JMP, S_FETCH};
        logic [16:0] ex [4] = '{E_FETCH_RDY, E_DEC, E_JMP, E_FETCH_RDY};
        opcode = OP_J; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL j[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st [5] = '{S_FETCH, S_DEC, S_EXR, S_RWB, S_FETCH};
        logic [16:0] ex [5] = '{E_FETCH_RDY, E_DEC, E_EXR, E_RWB, E_FETCH_RDY};
        opcode = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL rtype[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_addi();
        logic [3:0]  st [5] = '{S_FETCH, S_DEC, S_AEX, S_AWB, S_FETCH};
        logic [16:0] ex [5] = '{E_FETCH_RDY, E_DEC, E_AEX, E_AWB, E_FETCH_RDY};
        opcode = OP_ADDI; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL addi[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [3] = '{S_FETCH, S_DEC, S_FETCH};
        logic [16:0] ex [3] = '{E_FETCH_RDY, E_DEC_ILL, E_FETCH_RDY};
        opcode = OP_ILL; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({state, ctl} !== {st[i], ex[i]}) begin
                n_fail++;
                $display("FAIL illegal[%0d]: state=%0d ctl=%h, required %0d/%h", i, state, ctl, st[i], ex[i]);
            end
            if (i < 2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_mid_reset();
        opcode = OP_LW; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({state, ctl} !== {S_MRD, E_MRD}) begin
            n_fail++;
            $display("FAIL pre_reset_mrd: state=%0d ctl=%h, required %0d/%h", state, ctl, S_MRD, E_MRD);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({state, ctl, halted} !== {S_IDLE, E_IDLE, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d ctl=%h halted=%b, required 0/0/0", state, ctl, halted);
        end
        #1; rst_n = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({state, ctl} !== {S_FETCH, E_FETCH_RDY}) begin
            n_fail++;
            $display("FAIL resume_fetch: state=%0d ctl=%h, required %0d/%h",
                     state, ctl, S_FETCH, E_FETCH_RDY);
        end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0; opcode = OP_ILL;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({state, ctl, halted} !== {S_FETCH, E_FETCH_W, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: state=%0d ctl=%h halted=%b, required %0d/%h/0",
                         i, state, ctl, halted, S_FETCH, E_FETCH_W);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            #1;
            n_tests++;
            if ({state, ctl, halted} !== {S_IDLE, E_IDLE, 1'b1}) begin
                n_fail++;
                $display("FAIL timeout_halt[%0d]: state=%0d ctl=%h halted=%b, required 0/0/1",
                         i, state, ctl, halted);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            n_tests++;
            if ({state, ctl, halted} !== {S_FETCH, (i == 3) ? E_FETCH_RDY : E_FETCH_W, 1'b0}) begin
                n_fail++;
                $display("FAIL late_ready[%0d]: state=%0d ctl=%h halted=%b, required %0d/-/0",
                         i, state, ctl, halted, S_FETCH);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if ({state, ctl, halted} !== {S_DEC, E_DEC_ILL, 1'b0}) begin
            n_fail++;
            $display("FAIL late_ready_decode: state=%0d ctl=%h halted=%b, required %0d/%h/0",
                     state, ctl, halted, S_DEC, E_DEC_ILL);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_lw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump();
        test_rtype();
        test_addi();
        test_illegal();
        test_mid_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
